// File: rtl/spike_encoder_if.sv
// Address stream from spike_encoder toward the NoC injection port.
// Valid/ready handshake; the address is held stable while valid is high and ready is low.
interface spike_encoder_if #(
    parameter int ADDR_W = 12
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] source_address;

    modport master (output out_valid, output source_address, input out_ready);
    modport slave  (input out_valid, input source_address, output out_ready);
endinterface

// File: rtl/spike_encoder.sv
// Snapshots neuron spikes on clear and serialises them as base_address+index, lowest index first.
// One cycle from clear to first address; output holds under backpressure. Optional: SPIKE_ENCODER_COUNT_EN.
module spike_encoder #(
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = 12,
    parameter int IDX_W       = 3
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [ADDR_W-1:0]      base_address,
    input  logic [NUM_NEURONS-1:0] spikes,
    spike_encoder_if.master        out_if,
    output logic                   busy,
`ifdef SPIKE_ENCODER_COUNT_EN
    output logic [7:0]             spike_count,
`endif
    output logic                   overflow
);
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t                 r_state;
    logic [NUM_NEURONS-1:0] r_pending;
    logic [IDX_W-1:0]       r_idx;
    logic [ADDR_W-1:0]      r_source_address;
    logic                   r_busy;
    logic                   r_overflow;

    logic                   w_xfer;
    logic                   w_hold;
    logic [NUM_NEURONS-1:0] w_accepted;
    logic [NUM_NEURONS-1:0] w_remain;
    logic [NUM_NEURONS-1:0] w_snap;
    logic [NUM_NEURONS-1:0] w_pending_next;
    logic [IDX_W-1:0]       w_low_idx;
    logic                   w_collide;

    assign w_xfer         = (r_state == ST_SEND) && out_if.out_ready;
    assign w_hold         = (r_state == ST_SEND) && !out_if.out_ready;
    assign w_accepted     = w_xfer ? (NUM_NEURONS'(1) << r_idx) : '0;
    // Accepted bit is retired before the snapshot merges, so a re-spike is not a collision.
    assign w_remain       = r_pending & ~w_accepted;
    assign w_snap         = clear ? spikes : '0;
    assign w_pending_next = w_remain | w_snap;
    assign w_collide      = |(w_snap & w_remain);

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (w_pending_next[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    // A stalled presentation keeps its index and address even if a lower bit arrives.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_pending        <= '0;
            r_idx            <= '0;
            r_source_address <= '0;
            r_busy           <= 1'b0;
            r_overflow       <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_busy    <= |w_pending_next;
            if (w_collide) begin
                r_overflow <= 1'b1;
            end
            if (!w_hold) begin
                r_idx            <= w_low_idx;
                r_source_address <= base_address + ADDR_W'(w_low_idx);
                r_state          <= (|w_pending_next) ? ST_SEND : ST_IDLE;
            end
        end
    end

`ifdef SPIKE_ENCODER_COUNT_EN
    logic [7:0] r_spike_count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_spike_count <= '0;
        end else if (clear) begin
            r_spike_count <= {7'b0, w_xfer};
        end else if (w_xfer && (r_spike_count != 8'hFF)) begin
            r_spike_count <= r_spike_count + 8'd1;
        end
    end

    assign spike_count = r_spike_count;
`endif

    assign out_if.out_valid      = (r_state == ST_SEND);
    assign out_if.source_address = r_source_address;
    assign busy                  = r_busy;
    assign overflow              = r_overflow;
endmodule

// File: tb/tb_spike_encoder.sv
// Directed scenarios plus a randomized run against a set-of-pending-neurons reference model.
module tb_spike_encoder;
    localparam int N = 8;

    logic        CLK = 1'b0;
    logic        reset;
    logic        clear;
    logic [11:0] base_address;
    logic [N-1:0] spikes;
    logic        busy;
    logic        overflow;
`ifdef SPIKE_ENCODER_COUNT_EN
    logic [7:0]  spike_count;
`endif

    spike_encoder_if #(.ADDR_W(12)) bus ();

    spike_encoder #(.NUM_NEURONS(N), .ADDR_W(12), .IDX_W(3)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .clear        (clear),
        .base_address (base_address),
        .spikes       (spikes),
        .out_if       (bus.master),
        .busy         (busy),
`ifdef SPIKE_ENCODER_COUNT_EN
        .spike_count  (spike_count),
`endif
        .overflow     (overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; spikes = '0; bus.out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.source_address !== 12'h000 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b addr=%h busy=%b ovf=%b, want 0 000 0 0",
                     bus.out_valid, bus.source_address, busy, overflow);
        end
`ifdef SPIKE_ENCODER_COUNT_EN
        checks++;
        if (spike_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", spike_count);
        end
`endif
    endtask

    task automatic test_basic();
        logic [11:0] exp_a [3];
        exp_a[0] = 12'h100; exp_a[1] = 12'h102; exp_a[2] = 12'h105;
        do_reset();
        base_address = 12'h100; bus.out_ready = 1'b1;
        clear = 1'b1; spikes = 8'b0010_0101;
        tick();
        clear = 1'b0; spikes = '0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.source_address !== exp_a[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic[%0d]: valid=%b addr=%h busy=%b, want 1 %h 1",
                         k, bus.out_valid, bus.source_address, busy, exp_a[k]);
            end
            tick();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: valid=%b busy=%b ovf=%b, want 0 0 0", bus.out_valid, busy, overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_a [3];
        exp_a[0] = 12'h100; exp_a[1] = 12'h102; exp_a[2] = 12'h105;
        do_reset();
        base_address = 12'h100; bus.out_ready = 1'b0;
        clear = 1'b1; spikes = 8'b0010_0101;
        tick();
        clear = 1'b0; spikes = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.source_address !== 12'h100) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b addr=%h, want 1 100", k, bus.out_valid, bus.source_address);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.source_address !== exp_a[k]) begin
                errors++;
                $display("FAIL release[%0d]: valid=%b addr=%h, want 1 %h",
                         k, bus.out_valid, bus.source_address, exp_a[k]);
            end
            tick();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_end: valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_collision();
        do_reset();
        base_address = 12'h100; bus.out_ready = 1'b0;
        clear = 1'b1; spikes = 8'b0000_0011;
        tick();
        spikes = 8'b0000_0110;
        tick();
        clear = 1'b0; spikes = '0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL collision_ovf: got %b want 1", overflow);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.source_address !== 12'h100 + 12'(k)) begin
                errors++;
                $display("FAIL collision[%0d]: valid=%b addr=%h, want 1 %h",
                         k, bus.out_valid, bus.source_address, 12'h100 + 12'(k));
            end
            tick();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL collision_end: valid=%b ovf=%b, want 0 1", bus.out_valid, overflow);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        base_address = 12'h100; bus.out_ready = 1'b1;
        clear = 1'b1; spikes = 8'b0000_0001;
        tick();
        tick();
        clear = 1'b0; spikes = '0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.source_address !== 12'h100 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rearm: valid=%b addr=%h ovf=%b, want 1 100 0",
                     bus.out_valid, bus.source_address, overflow);
        end
`ifdef SPIKE_ENCODER_COUNT_EN
        checks++;
        if (spike_count !== 8'd1) begin
            errors++;
            $display("FAIL rearm_count: got %0d want 1", spike_count);
        end
`endif
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rearm_end: valid=%b ovf=%b, want 0 0", bus.out_valid, overflow);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        base_address = 12'hFFE; bus.out_ready = 1'b1;
        clear = 1'b1; spikes = 8'b1000_0010;
        tick();
        clear = 1'b0; spikes = '0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.source_address !== 12'hFFF) begin
            errors++;
            $display("FAIL wrap0: valid=%b addr=%h, want 1 fff", bus.out_valid, bus.source_address);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.source_address !== 12'h005) begin
            errors++;
            $display("FAIL wrap1: valid=%b addr=%h, want 1 005", bus.out_valid, bus.source_address);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        base_address = 12'h100; bus.out_ready = 1'b0;
        clear = 1'b1; spikes = 8'b0000_0011;
        tick();
        clear = 1'b0; spikes = 8'b0000_0010;
        tick();
        spikes = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || bus.source_address !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b ovf=%b addr=%h, want 0 0 0 000",
                     bus.out_valid, busy, overflow, bus.source_address);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet[%0d]: valid=%b want 0", k, bus.out_valid);
            end
        end
    endtask

    // Reference: a set of pending neurons; the presented neuron is the lowest
    // pending one, frozen while the consumer stalls.
    task automatic test_random();
        bit          m_pend [N];
        bit          m_valid;
        int          m_idx;
        bit          m_ovf;
        int          m_cnt;
        logic [11:0] base;
        bit          rdy, clr, xfer, any;
        logic [N-1:0] sp;
        do_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0; m_idx = 0; m_ovf = 1'b0; m_cnt = 0;
        base = 12'($urandom);
        base_address = base;
        for (int cyc = 0; cyc < 600; cyc++) begin
            any = 1'b0;
            foreach (m_pend[i]) any |= m_pend[i];
            checks++;
            if (bus.out_valid !== m_valid || busy !== any || overflow !== m_ovf ||
                (m_valid && bus.source_address !== 12'(base + 12'(m_idx)))) begin
                errors++;
                $display("FAIL random@%0d: valid=%b busy=%b ovf=%b addr=%h, want %b %b %b %h",
                         cyc, bus.out_valid, busy, overflow, bus.source_address,
                         m_valid, any, m_ovf, 12'(base + 12'(m_idx)));
            end
`ifdef SPIKE_ENCODER_COUNT_EN
            checks++;
            if (spike_count !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL random_count@%0d: got %0d want %0d", cyc, spike_count, m_cnt);
            end
`endif
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 5) == 0);
            sp  = N'($urandom);
            bus.out_ready = rdy; clear = clr; spikes = sp;
            xfer = m_valid && rdy;
            if (xfer) m_pend[m_idx] = 1'b0;
            if (clr) begin
                for (int i = 0; i < N; i++) begin
                    if (sp[i]) begin
                        if (m_pend[i]) m_ovf = 1'b1;
                        m_pend[i] = 1'b1;
                    end
                end
                m_cnt = xfer ? 1 : 0;
            end else if (xfer && m_cnt < 255) begin
                m_cnt++;
            end
            if (!(m_valid && !rdy)) begin
                m_valid = 1'b0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_pend[i]) begin
                        m_idx = i;
                        m_valid = 1'b1;
                    end
                end
            end
            tick();
        end
        clear = 1'b0; spikes = '0;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; spikes = '0; base_address = '0; bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_collision();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
